// File: rtl/placar_serial_tx.sv
// placar_serial_tx: sends each scoring event as an 8N1 UART text line, e.g. "G0007\n".
// Define PLACAR_CHECKSUM_EN to insert a two-character hex XOR checksum before the newline.
module placar_serial_tx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  input  logic [9:0] pontuacao,
  output logic       serial,
  output logic       busy,
  output logic [7:0] descartes,
  output logic [3:0] db_estado
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
`ifdef PLACAR_CHECKSUM_EN
  localparam int unsigned NBYTES = 8;
`else
  localparam int unsigned NBYTES = 6;
`endif
  localparam logic [2:0]    LAST_BYTE = 3'(NBYTES - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  // The PROXIMO cycle supplies the final stop-bit cycle, so STOP itself lasts DIV-1.
  localparam logic [CW-1:0] STOP_LAST = CW'(DIV - 2);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    CONVERTE = 4'd1,
    CARREGA  = 4'd2,
    START    = 4'd3,
    DADOS    = 4'd4,
    STOP     = 4'd5,
    PROXIMO  = 4'd6
  } state_t;

  logic [1:0]    rst_sync;
  logic          rst_n;
  state_t        state, state_d;
  logic          ev;
  logic [7:0]    ev_typ;
  logic          cap_active, cap_pend, pend_to_active, drop;
  logic          pend_valid;
  logic [7:0]    pend_typ;
  logic [9:0]    pend_score;
  logic [7:0]    typ;
  logic [10:0]   work;
  logic [10:0]   div_val;
  logic [1:0]    ph;
  logic [3:0]    d_mil, d_cen, d_dez;
  logic [2:0]    byte_idx, bit_cnt;
  logic [CW-1:0] baud_cnt;
  logic [7:0]    shreg, cur_byte;
  logic          bit_end, stop_end, conv_done, last_byte;

  // Asynchronous assertion, synchronised release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign ev        = ganhou_ponto | perdeu_ponto;
  assign ev_typ    = ganhou_ponto ? 8'h47 : 8'h50;
  assign bit_end   = (baud_cnt == BIT_LAST);
  assign stop_end  = (baud_cnt == STOP_LAST);
  assign last_byte = (byte_idx == LAST_BYTE);
  assign div_val   = (ph == 2'd0) ? 11'd1000 : (ph == 2'd1) ? 11'd100 : 11'd10;
  assign conv_done = (ph == 2'd2) && (work < 11'd10);
  assign db_estado = state;

`ifdef PLACAR_CHECKSUM_EN
  logic [7:0] csum;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign csum = typ ^ {4'h3, d_mil} ^ {4'h3, d_cen} ^ {4'h3, d_dez} ^ {4'h3, work[3:0]};
`endif

  // Byte selection; the units digit is the conversion remainder.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0:    cur_byte = typ;
      3'd1:    cur_byte = {4'h3, d_mil};
      3'd2:    cur_byte = {4'h3, d_cen};
      3'd3:    cur_byte = {4'h3, d_dez};
      3'd4:    cur_byte = {4'h3, work[3:0]};
`ifdef PLACAR_CHECKSUM_EN
      3'd5:    cur_byte = hex_char(csum[7:4]);
      3'd6:    cur_byte = hex_char(csum[3:0]);
`endif
      default: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= OCIOSO;
    else        state <= state_d;
  end

  // Next state and event routing (active, pending slot, or dropped).
  always_comb begin
    state_d        = state;
    cap_active     = 1'b0;
    cap_pend       = 1'b0;
    pend_to_active = 1'b0;
    drop           = 1'b0;
    if (ev) begin
      if (state == OCIOSO || (state == PROXIMO && last_byte && !pend_valid)) cap_active = 1'b1;
      else if (!pend_valid)                                                  cap_pend   = 1'b1;
      else                                                                   drop       = 1'b1;
    end
    case (state)
      OCIOSO:   if (ev) state_d = CONVERTE;
      CONVERTE: if (conv_done) state_d = CARREGA;
      CARREGA:  state_d = START;
      START:    if (bit_end) state_d = DADOS;
      DADOS:    if (bit_end && bit_cnt == 3'd7) state_d = STOP;
      STOP:     if (stop_end) state_d = PROXIMO;
      PROXIMO: begin
        if (!last_byte) state_d = CARREGA;
        else if (pend_valid) begin
          pend_to_active = 1'b1;
          state_d        = CONVERTE;
        end
        else if (ev) state_d = CONVERTE;
        else         state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      serial     <= 1'b1;
      busy       <= 1'b0;
      descartes  <= 8'h00;
      pend_valid <= 1'b0;
      pend_typ   <= 8'h00;
      pend_score <= 10'd0;
      typ        <= 8'h00;
      work       <= 11'd0;
      ph         <= 2'd0;
      d_mil      <= 4'd0;
      d_cen      <= 4'd0;
      d_dez      <= 4'd0;
      byte_idx   <= 3'd0;
      bit_cnt    <= 3'd0;
      baud_cnt   <= '0;
      shreg      <= 8'h00;
    end else begin
      busy <= (state_d != OCIOSO);
      if (drop && descartes != 8'hFF) descartes <= descartes + 8'd1;
      if (cap_pend) begin
        pend_valid <= 1'b1;
        pend_typ   <= ev_typ;
        pend_score <= pontuacao;
      end else if (pend_to_active) begin
        pend_valid <= 1'b0;
      end
      case (state)
        OCIOSO, PROXIMO: begin
          if (cap_active || pend_to_active) begin
            typ      <= cap_active ? ev_typ : pend_typ;
            work     <= cap_active ? {1'b0, pontuacao} : {1'b0, pend_score};
            ph       <= 2'd0;
            d_mil    <= 4'd0;
            d_cen    <= 4'd0;
            d_dez    <= 4'd0;
            byte_idx <= 3'd0;
          end else if (state == PROXIMO && !last_byte) begin
            byte_idx <= byte_idx + 3'd1;
          end
        end
        // One subtraction or one divisor step per cycle.
        CONVERTE: begin
          if (work >= div_val) begin
            work <= work - div_val;
            case (ph)
              2'd0:    d_mil <= d_mil + 4'd1;
              2'd1:    d_cen <= d_cen + 4'd1;
              default: d_dez <= d_dez + 4'd1;
            endcase
          end else if (ph != 2'd2) begin
            ph <= ph + 2'd1;
          end
        end
        CARREGA: begin
          shreg    <= cur_byte;
          serial   <= 1'b0;
          baud_cnt <= '0;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            serial   <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DADOS: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              serial <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              serial  <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP:    baud_cnt <= baud_cnt + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_placar_serial_tx.sv
// Bench for placar_serial_tx: a UART receiver decodes the line; expected text comes from decimal arithmetic.
module tb_placar_serial_tx;

  localparam int DIV       = 10;
  localparam int BIT_FRAME = 10 * DIV;
`ifdef PLACAR_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 6;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       ganhou_ponto = 1'b0;
  logic       perdeu_ponto = 1'b0;
  logic [9:0] pontuacao = 10'd0;
  logic       serial, busy;
  logic [7:0] descartes;
  logic [3:0] db_estado;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int exp_drop = 0;
  int busy_low = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  int rx_cnt = -1, rx_start_cyc = 0, prev_start = 0, n_starts = 0, rx_total = 0;
  logic [7:0] rx_sh = 8'h00;

  placar_serial_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clock(clock), .reset(reset), .ganhou_ponto(ganhou_ponto), .perdeu_ponto(perdeu_ponto),
    .pontuacao(pontuacao), .serial(serial), .busy(busy), .descartes(descartes), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-bit sampling UART receiver.
  always @(negedge clock) begin
    if (reset !== 1'b1) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (serial === 1'b0) begin
        prev_start   = rx_start_cyc;
        rx_start_cyc = cyc;
        n_starts++;
        rx_cnt = 0;
        if ((rx_total % NB) != 0)
          chk("byte_gap", 32'((rx_start_cyc - prev_start >= BIT_FRAME) &&
                              (rx_start_cyc - prev_start <= BIT_FRAME + 1)), 32'd1);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == DIV / 2) chk("rx_start_bit", 32'(serial), 32'd0);
      else if (rx_cnt > DIV / 2 && rx_cnt < 9 * DIV && (rx_cnt % DIV) == DIV / 2)
        rx_sh = {serial, rx_sh[7:1]};
      else if (rx_cnt == 9 * DIV + DIV / 2) begin
        chk("rx_stop_bit", 32'(serial), 32'd1);
        rx_q.push_back(rx_sh);
        rx_total++;
        rx_cnt = -1;
      end
    end
  end

  function automatic logic [7:0] hexc(input int n);
    string h = "0123456789ABCDEF";
    return h[n];
  endfunction

  function automatic void push_frame(input bit g, input int score);
    logic [7:0] b[5];
    logic [7:0] x = 8'h00;
    b[0] = g ? "G" : "P";
    b[1] = 8'(48 + score / 1000);
    b[2] = 8'(48 + (score / 100) % 10);
    b[3] = 8'(48 + (score / 10) % 10);
    b[4] = 8'(48 + score % 10);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(b[i]);
      x ^= b[i];
    end
`ifdef PLACAR_CHECKSUM_EN
    exp_q.push_back(hexc(int'(x) / 16));
    exp_q.push_back(hexc(int'(x) % 16));
`endif
    exp_q.push_back(8'h0A);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input bit g, input bit p, input int score);
    ganhou_ponto = g;
    perdeu_ponto = p;
    pontuacao    = 10'(score);
    @(negedge clock);
    ganhou_ponto = 1'b0;
    perdeu_ponto = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    busy_low = 0;
    while (rx_q.size() < n && k < 5000) begin
      @(negedge clock);
      k++;
      if (busy !== 1'b1) busy_low++;
    end
    chk(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 500) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(cyc - rx_start_cyc), 32'(BIT_FRAME));
  endtask

  task automatic compare_frames(input string tag);
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic run_single(input bit g, input bit p, input int score, input string tag);
    int s0 = n_starts;
    int cap;
    int k = 0;
    pulse(g, p, score);
    cap = cyc;
    push_frame(g, score);
    chk({tag, "_busy_set"}, 32'(busy), 32'd1);
    chk({tag, "_state_active"}, 32'(db_estado != 4'd0), 32'd1);
    while (n_starts == s0 && k < 64) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_latency"}, 32'(n_starts != s0 && rx_start_cyc - cap <= 32), 32'd1);
    wait_bytes(NB, {tag, "_rx"});
    wait_idle({tag, "_busy_fall"});
    compare_frames(tag);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, kind, extra, k;
    bit g, p;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_serial", 32'(serial), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_descartes", 32'(descartes), 32'd0);
    chk("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b1;
    cycles(5);
    chk("idle_serial", 32'(serial), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    run_single(1'b1, 1'b0, 7, "g7");
    run_single(1'b0, 1'b1, 1023, "p1023");
    run_single(1'b1, 1'b1, 500, "both500");
    run_single(1'b1, 1'b0, 0, "g0");

    // Three events inside one frame: one pending, one dropped.
    pulse(1'b1, 1'b0, 10);
    push_frame(1'b1, 10);
    cycles(100);
    pulse(1'b1, 1'b0, 11);
    push_frame(1'b1, 11);
    cycles(3);
    pulse(1'b0, 1'b1, 12);
    exp_drop++;
    wait_bytes(2 * NB, "three_rx");
    chk("three_busy_held", 32'(busy_low), 32'd0);
    wait_idle("three_busy_fall");
    compare_frames("three");
    chk("three_drops", 32'(descartes), 32'(exp_drop));

    // Score input churns after capture.
    pulse(1'b1, 1'b0, 42);
    push_frame(1'b1, 42);
    k = 0;
    while (rx_q.size() < NB && k < 5000) begin
      pontuacao = 10'($urandom);
      @(negedge clock);
      k++;
    end
    chk("hold_rx", 32'(rx_q.size() >= NB), 32'd1);
    wait_idle("hold_busy_fall");
    compare_frames("hold42");

    // Event on the very edge the last stop bit ends.
    pulse(1'b1, 1'b0, 100);
    push_frame(1'b1, 100);
    wait_bytes(NB, "edge_rx1");
    k = 0;
    while (cyc < rx_start_cyc + BIT_FRAME - 1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    pulse(1'b0, 1'b1, 200);
    push_frame(1'b0, 200);
    wait_bytes(2 * NB, "edge_rx2");
    wait_idle("edge_busy_fall");
    compare_frames("edge");
    chk("edge_drops", 32'(descartes), 32'(exp_drop));

    // Randomised events, with 0..3 extra events during each frame.
    for (int it = 0; it < 6; it++) begin
      s     = $urandom_range(0, 1023);
      kind  = $urandom_range(0, 2);
      extra = $urandom_range(0, 3);
      g = (kind != 1);
      p = (kind != 0);
      pulse(g, p, s);
      push_frame(g, s);
      for (int j = 0; j < extra; j++) begin
        cycles($urandom_range(40, 80));
        s    = $urandom_range(0, 1023);
        kind = $urandom_range(0, 2);
        g = (kind != 1);
        p = (kind != 0);
        pulse(g, p, s);
        if (j == 0) push_frame(g, s);
        else if (exp_drop < 255) exp_drop++;
      end
      wait_bytes(exp_q.size(), "rand_rx");
      wait_idle("rand_busy_fall");
      compare_frames("rand");
      chk("rand_drops", 32'(descartes), 32'(exp_drop));
    end

    // 300 events during one frame saturate the drop counter.
    pulse(1'b1, 1'b0, 5);
    push_frame(1'b1, 5);
    cycles(50);
    for (int i = 0; i < 300; i++) begin
      ganhou_ponto = 1'b1;
      pontuacao    = 10'(600 + i);
      @(negedge clock);
    end
    ganhou_ponto = 1'b0;
    push_frame(1'b1, 600);
    exp_drop = (exp_drop + 299 > 255) ? 255 : exp_drop + 299;
    wait_bytes(2 * NB, "sat_rx");
    wait_idle("sat_busy_fall");
    compare_frames("sat");
    chk("sat_drops", 32'(descartes), 32'(exp_drop));

    // Reset during the start bit of byte 2 with an event pending.
    pulse(1'b1, 1'b0, 33);
    push_frame(1'b1, 33);
    cycles(100);
    pulse(1'b1, 1'b0, 44);
    wait_bytes(2, "rst_rx");
    k = 0;
    while (serial !== 1'b0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("rst_in_byte2", 32'(serial), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_serial", 32'(serial), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_descartes", 32'(descartes), 32'd0);
    chk("rst_mid_estado", 32'(db_estado), 32'd0);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    compare_frames("rst_partial");
    exp_drop = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    cycles(1500);
    chk("rst_no_frames", 32'(rx_q.size()), 32'd0);
    chk("rst_after_serial", 32'(serial), 32'd1);
    chk("rst_after_busy", 32'(busy), 32'd0);
    chk("rst_after_descartes", 32'(descartes), 32'(exp_drop));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
